// File: rtl/dmem_port_arbiter.sv
// Two-port data-memory arbiter: port 0 (pipeline) has default priority, and port 1 is
// protected from starvation. The winning request is registered and presented to memory for one cycle.
module dmem_port_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [2:0]            p0_funct3,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [2:0]            p1_funct3,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_err,

    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd,
    output logic                  busy
);

    localparam int CW = 4;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic [DM_ADDRESS-1:0] addr_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            f3_q;
    logic                  port_q;

    logic                  p0_rvalid_q, p1_rvalid_q;
    logic [DATA_W-1:0]     p0_rdata_q, p1_rdata_q;
    logic                  p0_err_q, p1_err_q;

    logic                  starve_hit;
    logic                  gnt0, gnt1;
    logic                  mis;
    logic                  access;
    logic                  ret0, ret1;

    // Grants are gated by reset so nothing is accepted while the block is held in reset.
    assign starve_hit = (starve_q == CW'(STARVE_MAX));
    assign gnt1       = reset_n & p1_req & (~p0_req | starve_hit);
    assign gnt0       = reset_n & p0_req & ~gnt1;

    // Only W and H have alignment constraints; unknown size codes pass through unflagged.
    assign mis = ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00)) ||
                 ((f3_q == 3'b001) && addr_q[0]);

    assign access = (state_q == ACCESS);
    assign ret0   = access & ~port_q & (~we_q | mis);
    assign ret1   = access &  port_q & (~we_q | mis);

    always_comb begin
        state_d  = IDLE;
        starve_d = starve_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        busy     = 1'b0;
        if (gnt0 || gnt1) begin
            state_d = ACCESS;
        end
        if (!p1_req || gnt1) begin
            starve_d = '0;
        end else if (gnt0 && !starve_hit) begin
            starve_d = starve_q + CW'(1);
        end
        if (state_q == ACCESS) begin
            busy     = 1'b1;
            MemRead  = ~we_q & ~mis;
            MemWrite =  we_q & ~mis;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            f3_q    <= '0;
            port_q  <= 1'b0;
        end else if (gnt1) begin
            addr_q  <= p1_addr;
            we_q    <= p1_we;
            wdata_q <= p1_wdata;
            f3_q    <= p1_funct3;
            port_q  <= 1'b1;
        end else if (gnt0) begin
            addr_q  <= p0_addr;
            we_q    <= p0_we;
            wdata_q <= p0_wdata;
            f3_q    <= p0_funct3;
            port_q  <= 1'b0;
        end
    end

    // Response stage: rd is captured at the end of the access cycle; rdata/err hold between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
        end else begin
            p0_rvalid_q <= ret0;
            p1_rvalid_q <= ret1;
            if (ret0) begin
                p0_rdata_q <= mis ? '0 : rd;
                p0_err_q   <= mis;
            end
            if (ret1) begin
                p1_rdata_q <= mis ? '0 : rd;
                p1_err_q   <= mis;
            end
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign a         = addr_q;
    assign wd        = wdata_q;
    assign Funct3    = f3_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter checked against a transaction-level model
// of grants, starvation, memory strobes and read returns.
module tb_dmem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int SM = 4;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          MemRead, MemWrite, busy;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [2:0]    Funct3;
    logic [DW-1:0] rd;

    // Requester state per port.
    bit            rq [2];
    bit            req_we [2];
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_wd [2];
    logic [2:0]    req_f3 [2];

    dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(rq[0]), .p0_we(req_we[0]), .p0_addr(req_addr[0]), .p0_wdata(req_wd[0]),
        .p0_funct3(req_f3[0]), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_req(rq[1]), .p1_we(req_we[1]), .p1_addr(req_addr[1]), .p1_wdata(req_wd[1]),
        .p1_funct3(req_f3[1]), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
        .rd(rd), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        bit            v;
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic [2:0]    f3;
    } acc_t;

    int            cnt;
    acc_t          acc;
    bit            rv_e [2];
    logic [DW-1:0] rdat_e [2];
    bit            err_e [2];
    logic [AW-1:0] a_e;
    logic [DW-1:0] wd_e;
    logic [2:0]    f3_e;
    bit            g0, g1;

    function automatic bit misal(input logic [2:0] f3, input logic [AW-1:0] ad);
        return ((f3 == 3'b010) && (ad[1:0] != 2'b00)) || ((f3 == 3'b001) && ad[0]);
    endfunction

    task automatic model_reset();
        cnt = 0;
        acc.v = 0;
        for (int p = 0; p < 2; p++) begin
            rv_e[p] = 0; rdat_e[p] = '0; err_e[p] = 0;
        end
        a_e = '0; wd_e = '0; f3_e = '0;
    endtask

    task automatic new_req(input int p);
        logic [2:0] f3tab [8];
        logic [AW-1:0] ad;
        f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b010, 3'b010};
        ad = AW'($urandom_range(0, 511));
        if ($urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
        rq[p]       = 1;
        req_we[p]   = 1'($urandom_range(0, 1));
        req_addr[p] = ad;
        req_wd[p]   = $urandom;
        req_f3[p]   = f3tab[$urandom_range(0, 7)];
    endtask

    task automatic drive(input int mode, input bit gg0, input bit gg1);
        for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? gg0 : gg1) rq[p] = 0;
            if (mode == 1) begin
                if (!rq[p]) new_req(p);
            end else if (rq[p]) begin
                if ($urandom_range(0, 9) == 0) rq[p] = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                new_req(p);
            end
        end
        rd = $urandom;
    endtask

    task automatic check_cycle(output bit og0, output bit og1);
        bit e0, e1, m;
        int p;
        e1 = rq[1] && (!rq[0] || cnt >= SM);
        e0 = rq[0] && !e1;
        m  = acc.v && misal(acc.f3, acc.addr);
        chk("p0_gnt", p0_gnt, e0);
        chk("p1_gnt", p1_gnt, e1);
        chk("busy", busy, acc.v);
        chk("MemRead", MemRead, acc.v && !acc.we && !m);
        chk("MemWrite", MemWrite, acc.v && acc.we && !m);
        chk("a", a, a_e);
        chk("wd", wd, wd_e);
        chk("Funct3", Funct3, f3_e);
        chk("p0_rvalid", p0_rvalid, rv_e[0]);
        chk("p0_rdata", p0_rdata, rdat_e[0]);
        chk("p0_err", p0_err, err_e[0]);
        chk("p1_rvalid", p1_rvalid, rv_e[1]);
        chk("p1_rdata", p1_rdata, rdat_e[1]);
        chk("p1_err", p1_err, err_e[1]);
        // Advance the model across the coming clock edge.
        rv_e[0] = 0;
        rv_e[1] = 0;
        if (acc.v && (m || !acc.we)) begin
            rv_e[acc.port]   = 1;
            rdat_e[acc.port] = m ? '0 : rd;
            err_e[acc.port]  = m;
        end
        if (e0 || e1) begin
            p = e1 ? 1 : 0;
            acc.v = 1; acc.port = e1; acc.we = req_we[p];
            acc.addr = req_addr[p]; acc.wdat = req_wd[p]; acc.f3 = req_f3[p];
            a_e = req_addr[p]; wd_e = req_wd[p]; f3_e = req_f3[p];
        end else begin
            acc.v = 0;
        end
        if (e1 || !rq[1]) cnt = 0;
        else if (e0 && cnt < SM) cnt++;
        og0 = e0;
        og1 = e1;
    endtask

    initial begin
        bit did_rst, hit;
        int mode;
        did_rst = 0;
        reset_n = 1'b0;
        rd = '0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; req_we[p] = 0; req_addr[p] = '0; req_wd[p] = '0; req_f3[p] = '0;
        end
        model_reset();
        new_req(0);
        new_req(1);
        #2;
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_MemRead", MemRead, 0);
        chk("rst_MemWrite", MemWrite, 0);
        chk("rst_a", a, 0);
        chk("rst_wd", wd, 0);
        chk("rst_Funct3", Funct3, 0);
        chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
        chk("rst_err", {p0_err, p1_err}, 0);
        @(posedge clk);
        g0 = 0;
        g1 = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (!reset_n) reset_n = 1'b1;
            mode = (cyc < 60 || (cyc >= 1500 && cyc < 1560)) ? 1 : 0;
            drive(mode, g0, g1);
            @(negedge clk);
            hit = acc.v && !acc.port && !acc.we && !misal(acc.f3, acc.addr);
            check_cycle(g0, g1);
            if (hit && !did_rst && cyc >= 1000) begin
                did_rst = 1;
                #1 reset_n = 1'b0;
                #1;
                chk("arst_MemRead", MemRead, 0);
                chk("arst_busy", busy, 0);
                chk("arst_gnt", {p0_gnt, p1_gnt}, 0);
                chk("arst_a", a, 0);
                model_reset();
                g0 = 0;
                g1 = 0;
            end
        end
        chk("rst_event_seen", did_rst, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data memory.
- Port 0 is the pipeline MEM stage; port 1 is a secondary master (program loader/debug).
- Accepts req/gnt requests, registers the winning request, and drives MemRead/MemWrite/a/wd/Funct3 for exactly one cycle per access.
- Returns read data with fixed latency and blocks misaligned accesses.

Parameters:
- DM_ADDRESS, 9, width of the memory byte address.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive port-1 losses before port 1 is forced to win; range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous reset, active-low.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  1 = store, 0 = load.
- p0_addr  in  DM_ADDRESS  byte address.
- p0_wdata  in  DATA_W  store data.
- p0_funct3  in  3  access size/sign code (000 B, 001 H, 010 W, 100 BU).
- p0_gnt  out  1  request accepted this cycle.
- p0_rvalid  out  1  read data / error valid pulse.
- p0_rdata  out  DATA_W  read data.
- p0_err  out  1  misalignment flag, qualified by p0_rvalid.
- p1_*  same set as p0_*, for port 1.
- MemRead  out  1  to memory.
- MemWrite  out  1  to memory.
- a  out  DM_ADDRESS  to memory.
- wd  out  DATA_W  to memory.
- Funct3  out  3  to memory.
- rd  in  DATA_W  from memory; valid during the access cycle.
- busy  out  1  access in progress (ACCESS state).

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE, starvation counter 0.
  - All outputs 0: gnt, rvalid, rdata, err, MemRead, MemWrite, a, wd, Funct3, busy.
- States:
  - IDLE: no access in flight.
  - ACCESS: registered request driven to memory for one cycle.
- Grant:
  - Combinational in IDLE or ACCESS when any req is high; at most one gnt per cycle.
  - On the gnt edge, addr/we/wdata/funct3/port-id are latched and the next state is ACCESS.
  - With no grant, the next state is IDLE.
  - Back-to-back grants sustain one access per cycle.
- Requester rule: req and all fields are held stable until gnt. req may deassert before gnt; the request is then withdrawn with no side effect.
- Priority:
  - Port 0 wins by default.
  - The starvation counter increments on each cycle p1_req is high and p0 is granted instead.
  - When the counter equals STARVE_MAX, p1 wins the next arbitration even if p0_req is high.
  - The counter clears on a p1 grant or when p1_req is low. It saturates at STARVE_MAX.
- ACCESS cycle:
  - a, wd, Funct3 are driven from the latch.
  - For a load, MemRead=1 and MemWrite=0. For a store, MemWrite=1 and MemRead=0.
  - busy=1.
  - Outside ACCESS, MemRead and MemWrite are 0; a, wd, Funct3 hold their last values.
- Misalignment:
  - Defined as W with addr[1:0]!=0, or H with addr[0]!=0.
  - The ACCESS cycle still occurs (busy=1) but MemRead and MemWrite stay 0.
  - The owning port gets rvalid=1, err=1, rdata=0 the following cycle, for loads and stores alike.
- Read return:
  - rd is sampled at the end of the ACCESS cycle.
  - The owning port's rvalid pulses the next cycle with rdata=rd and err=0. Latency from gnt to rvalid is 2 edges.
  - rdata holds until the next rvalid of that port.
  - An aligned store produces no rvalid.
- Simultaneous events:
  - A gnt in the same cycle as a previous access's rvalid is legal.
  - A port may receive rvalid for access N while being granted access N+1.
- Reset during ACCESS or before rvalid: the access is abandoned with no rvalid. Memory-side strobes drop immediately.
- Funct3 values outside {000,001,010,100} are passed through unchanged and are never flagged misaligned.

Test Plan:
- Single p0 load: addr=0x010, funct3=010, memory rd=0xDEADBEEF → p0_gnt in cycle 0, MemRead=1 and a=0x010 in cycle 1, p0_rvalid=1 with p0_rdata=0xDEADBEEF in cycle 2.
- Back-to-back p0 stores to 0x000, 0x004, 0x008 (funct3=010) → three consecutive gnt cycles, then three consecutive MemWrite cycles with matching a/wd; no rvalid.
- Starvation, STARVE_MAX=4:
  - Stimulus: p0_req and p1_req both held high.
  - Expected: p0 granted for 4 cycles, p1 granted on the 5th, counter cleared, then p0 granted again.
- Misaligned p1 LW at addr=0x006 → busy=1 for one cycle with MemRead=0, then p1_rvalid=1, p1_err=1, p1_rdata=0.
- Misaligned p0 SH at addr=0x003 → MemWrite never asserts; p0_rvalid=1, p0_err=1.
- reset_n driven low during an ACCESS cycle of a p0 load → MemRead drops to 0 immediately; no p0_rvalid after release; the next request is granted normally from IDLE.
